// File: rtl/gshare_bp_pkg.sv
// Shared types and sizing for the gshare fetch predictor.
// Counter states, branch kinds, BTB entry layout, RAS widths.
package gshare_bp_pkg;

    localparam int XLEN        = 32;
    localparam int BHT_ENTRIES = 256;
    localparam int GHR_W       = 8;
    localparam int BTB_ENTRIES = 64;
    localparam int RAS_DEPTH   = 8;

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W = XLEN - 2 - BTB_IDX_W;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = RAS_PTR_W + 1;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JMP  = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_type_e;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        br_type_e             btype;
        logic [XLEN-1:0]      target;
    } btb_entry_t;

    // Two-bit saturating counter step.
    function automatic ctr_e ctr_next(ctr_e c, logic taken);
        if (taken)
            return (c == ST) ? ST : ctr_e'(c + 2'd1);
        else
            return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/gshare_bp_if.sv
// Fetch/execute bundle of the gshare predictor.
// master = fetch/execute side, slave = predictor.
interface gshare_bp_if;
    import gshare_bp_pkg::*;

    logic [XLEN-1:0]      pc_i;
    logic                 fetch_fire_i;
    logic [XLEN-1:0]      next_pc_o;
    logic                 next_taken_o;
    logic [GHR_W-1:0]     pred_ghr_o;
    logic                 br_req_i;
    logic [XLEN-1:0]      br_pc_i;
    logic [XLEN-1:0]      br_target_i;
    logic                 br_taken_i;
    logic                 br_is_call_i;
    logic                 br_is_ret_i;
    logic                 br_is_jmp_i;
    logic                 br_mispredict_i;
    logic [GHR_W-1:0]     br_ghr_i;
    logic [RAS_CNT_W-1:0] ras_count_o;

    modport master (
        output pc_i, fetch_fire_i,
        output br_req_i, br_pc_i, br_target_i, br_taken_i,
        output br_is_call_i, br_is_ret_i, br_is_jmp_i,
        output br_mispredict_i, br_ghr_i,
        input  next_pc_o, next_taken_o, pred_ghr_o, ras_count_o
    );

    modport slave (
        input  pc_i, fetch_fire_i,
        input  br_req_i, br_pc_i, br_target_i, br_taken_i,
        input  br_is_call_i, br_is_ret_i, br_is_jmp_i,
        input  br_mispredict_i, br_ghr_i,
        output next_pc_o, next_taken_o, pred_ghr_o, ras_count_o
    );

endinterface

// File: rtl/gshare_bp_ras.sv
// Return address stack: circular buffer, speculative + committed ptr/count.
// Ports: spec push/pop, committed push/pop, restore (+optional top write), top/count.
module bp_ras
    import gshare_bp_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 spec_push_i,
    input  logic                 spec_pop_i,
    input  logic [XLEN-1:0]      push_addr_i,
    input  logic                 com_push_i,
    input  logic                 com_pop_i,
    input  logic                 restore_i,
    input  logic                 restore_wr_i,
    input  logic [XLEN-1:0]      restore_addr_i,
    output logic [XLEN-1:0]      top_o,
    output logic [RAS_CNT_W-1:0] count_o
);

    localparam logic [RAS_CNT_W-1:0] FULL = RAS_CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]      mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] sp_q, cp_q, cp_n;
    logic [RAS_CNT_W-1:0] sc_q, cc_q, cc_n;

    // ptr addresses the next free slot; when full it is also the oldest.
    assign top_o   = mem[sp_q - 1'b1];
    assign count_o = sc_q;

    always_comb begin
        cp_n = cp_q;
        cc_n = cc_q;
        if (com_push_i) begin
            cp_n = cp_q + 1'b1;
            cc_n = (cc_q == FULL) ? FULL : cc_q + 1'b1;
        end else if (com_pop_i && cc_q != '0) begin
            cp_n = cp_q - 1'b1;
            cc_n = cc_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= '0;
            sc_q <= '0;
            cp_q <= '0;
            cc_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            cp_q <= cp_n;
            cc_q <= cc_n;
            if (restore_i) begin
                sp_q <= cp_n;
                sc_q <= cc_n;
                // a restoring call's new top sits where cp pointed
                if (restore_wr_i)
                    mem[cp_q] <= restore_addr_i;
            end else if (spec_push_i) begin
                mem[sp_q] <= push_addr_i;
                sp_q      <= sp_q + 1'b1;
                sc_q      <= (sc_q == FULL) ? FULL : sc_q + 1'b1;
            end else if (spec_pop_i && sc_q != '0) begin
                sp_q <= sp_q - 1'b1;
                sc_q <= sc_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// Fetch-stage gshare predictor with tagged BTB and speculative RAS.
// Ports: clk_i, rst_i (async, high), bp (slave: fetch lookup + execute resolution).
module gshare_bp
    import gshare_bp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    gshare_bp_if.slave  bp
);

    ctr_e             bht [BHT_ENTRIES];
    btb_entry_t       btb [BTB_ENTRIES];
    logic [GHR_W-1:0] ghr_q;

    logic [XLEN-1:0]      f_seq_pc;
    logic [BTB_IDX_W-1:0] f_idx;
    logic [BTB_TAG_W-1:0] f_tag;
    btb_entry_t           f_ent;
    logic                 f_hit;
    logic [BHT_IDX_W-1:0] rd_idx;
    logic                 f_cond_tk;
    logic                 f_go;
    logic [XLEN-1:0]      npc;
    logic                 ntk;

    logic [XLEN-1:0]      ras_top;
    logic [RAS_CNT_W-1:0] ras_cnt;

    br_type_e             r_type;
    logic                 r_cond;
    logic                 mp;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [BTB_IDX_W-1:0] r_idx;
    logic [BTB_TAG_W-1:0] r_tag;

    assign f_seq_pc  = bp.pc_i + XLEN'(4);
    assign f_idx     = bp.pc_i[2 +: BTB_IDX_W];
    assign f_tag     = bp.pc_i[XLEN-1 -: BTB_TAG_W];
    assign f_ent     = btb[f_idx];
    assign f_hit     = f_ent.valid && (f_ent.tag == f_tag);
    assign rd_idx    = bp.pc_i[2 +: BHT_IDX_W]
                     ^ BHT_IDX_W'(ghr_q);
    assign f_cond_tk = bht[rd_idx][1];

    always_comb begin
        npc = f_seq_pc;
        ntk = 1'b0;
        if (f_hit) begin
            unique case (f_ent.btype)
                BR_COND: begin
                    if (f_cond_tk) begin
                        ntk = 1'b1;
                        npc = f_ent.target;
                    end
                end
                BR_JMP, BR_CALL: begin
                    ntk = 1'b1;
                    npc = f_ent.target;
                end
                BR_RET: begin
                    ntk = 1'b1;
                    npc = (ras_cnt != '0) ? ras_top
                                          : f_ent.target;
                end
            endcase
        end
    end

    assign bp.next_pc_o    = npc;
    assign bp.next_taken_o = ntk;
    assign bp.pred_ghr_o   = ghr_q;
    assign bp.ras_count_o  = ras_cnt;

    always_comb begin
        r_type = BR_COND;
        unique case (1'b1)
            bp.br_is_call_i: r_type = BR_CALL;
            bp.br_is_ret_i:  r_type = BR_RET;
            bp.br_is_jmp_i:  r_type = BR_JMP;
            default:         r_type = BR_COND;
        endcase
    end

    assign r_cond  = (r_type == BR_COND);
    assign mp      = bp.br_req_i & bp.br_mispredict_i;
    assign upd_idx = bp.br_pc_i[2 +: BHT_IDX_W]
                   ^ BHT_IDX_W'(bp.br_ghr_i);
    assign r_idx   = bp.br_pc_i[2 +: BTB_IDX_W];
    assign r_tag   = bp.br_pc_i[XLEN-1 -: BTB_TAG_W];

    // Fetch-side speculation is dropped whenever a repair lands.
    assign f_go = bp.fetch_fire_i & f_hit & ~mp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ghr_q <= '0;
        else if (mp)
            ghr_q <= r_cond
                   ? GHR_W'({bp.br_ghr_i, bp.br_taken_i})
                   : bp.br_ghr_i;
        else if (f_go && f_ent.btype == BR_COND)
            ghr_q <= GHR_W'({ghr_q, f_cond_tk});
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= WNT;
        end else if (bp.br_req_i && r_cond) begin
            bht[upd_idx] <= ctr_next(bht[upd_idx], bp.br_taken_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                btb[i] <= '0;
        end else if (bp.br_req_i && bp.br_taken_i) begin
            btb[r_idx] <= '{valid:  1'b1,
                            tag:    r_tag,
                            btype:  r_type,
                            target: bp.br_target_i};
        end
    end

    bp_ras u_ras (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .spec_push_i    (f_go && f_ent.btype == BR_CALL),
        .spec_pop_i     (f_go && f_ent.btype == BR_RET),
        .push_addr_i    (f_seq_pc),
        .com_push_i     (bp.br_req_i && r_type == BR_CALL),
        .com_pop_i      (bp.br_req_i && r_type == BR_RET),
        .restore_i      (mp),
        .restore_wr_i   (mp && r_type == BR_CALL),
        .restore_addr_i (bp.br_pc_i + XLEN'(4)),
        .top_o          (ras_top),
        .count_o        (ras_cnt)
    );

endmodule

// File: tb/tb_gshare_bp.sv
// Randomized + directed bench for gshare_bp against a behavioural model.
// Drives at negedge, compares combinational outputs before the next posedge.
module tb_gshare_bp;
    import gshare_bp_pkg::*;

    localparam int T_COND = 0;
    localparam int T_JMP  = 1;
    localparam int T_CALL = 2;
    localparam int T_RET  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gshare_bp_if bpif();

    gshare_bp dut (
        .clk_i (clk),
        .rst_i (rst),
        .bp    (bpif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model state
    int          m_ctr [BHT_ENTRIES];
    bit          m_v   [BTB_ENTRIES];
    logic [31:0] m_tag [BTB_ENTRIES];
    int          m_ty  [BTB_ENTRIES];
    logic [31:0] m_tgt [BTB_ENTRIES];
    int          m_ghr;
    logic [31:0] m_ras [RAS_DEPTH];
    int          m_sp, m_sc, m_cp, m_cc;

    task automatic model_reset();
        for (int i = 0; i < BHT_ENTRIES; i++) m_ctr[i] = 1;
        for (int i = 0; i < BTB_ENTRIES; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_ty[i] = 0; m_tgt[i] = 0;
        end
        for (int i = 0; i < RAS_DEPTH; i++) m_ras[i] = 0;
        m_ghr = 0; m_sp = 0; m_sc = 0; m_cp = 0; m_cc = 0;
    endtask

    function automatic int btb_slot(logic [31:0] pc);
        return int'((pc >> 2) % BTB_ENTRIES);
    endfunction

    function automatic logic [31:0] btb_tagof(logic [31:0] pc);
        return pc >> (2 + $clog2(BTB_ENTRIES));
    endfunction

    task automatic m_lookup(input logic [31:0] pc, output bit hit,
                            output int ty, output logic [31:0] npc,
                            output bit tk);
        int s;
        int bi;
        s   = btb_slot(pc);
        hit = m_v[s] && m_tag[s] == btb_tagof(pc);
        ty  = m_ty[s];
        npc = pc + 4;
        tk  = 0;
        if (hit) begin
            case (ty)
                T_COND: begin
                    bi = int'((pc >> 2) % BHT_ENTRIES) ^ m_ghr;
                    if (m_ctr[bi] >= 2) begin
                        tk = 1; npc = m_tgt[s];
                    end
                end
                T_RET: begin
                    tk = 1;
                    npc = (m_sc > 0)
                        ? m_ras[(m_sp + RAS_DEPTH - 1) % RAS_DEPTH]
                        : m_tgt[s];
                end
                default: begin
                    tk = 1; npc = m_tgt[s];
                end
            endcase
        end
    endtask

    task automatic m_update(bit hit, int fty, bit ftk);
        logic [31:0] bpc;
        int rty, ncp, ncc, bi, s;
        bit mp;
        bpc = bpif.br_pc_i;
        rty = bpif.br_is_call_i ? T_CALL :
              bpif.br_is_ret_i  ? T_RET  :
              bpif.br_is_jmp_i  ? T_JMP  : T_COND;
        mp  = bpif.br_req_i && bpif.br_mispredict_i;
        ncp = m_cp; ncc = m_cc;
        if (bpif.br_req_i) begin
            if (rty == T_COND) begin
                bi = int'((bpc >> 2) % BHT_ENTRIES) ^ int'(bpif.br_ghr_i);
                if (bpif.br_taken_i)
                    m_ctr[bi] = (m_ctr[bi] == 3) ? 3 : m_ctr[bi] + 1;
                else
                    m_ctr[bi] = (m_ctr[bi] == 0) ? 0 : m_ctr[bi] - 1;
            end
            if (bpif.br_taken_i) begin
                s = btb_slot(bpc);
                m_v[s] = 1; m_tag[s] = btb_tagof(bpc);
                m_ty[s] = rty; m_tgt[s] = bpif.br_target_i;
            end
            if (rty == T_CALL) begin
                ncp = (m_cp + 1) % RAS_DEPTH;
                ncc = (m_cc < RAS_DEPTH) ? m_cc + 1 : RAS_DEPTH;
            end else if (rty == T_RET && m_cc > 0) begin
                ncp = (m_cp + RAS_DEPTH - 1) % RAS_DEPTH;
                ncc = m_cc - 1;
            end
            m_cp = ncp; m_cc = ncc;
        end
        if (mp) begin
            if (rty == T_COND)
                m_ghr = ((int'(bpif.br_ghr_i) * 2) + int'(bpif.br_taken_i))
                        % (1 << GHR_W);
            else
                m_ghr = int'(bpif.br_ghr_i);
            m_sp = ncp; m_sc = ncc;
            if (rty == T_CALL)
                m_ras[(ncp + RAS_DEPTH - 1) % RAS_DEPTH] = bpc + 4;
        end else if (bpif.fetch_fire_i && hit) begin
            if (fty == T_COND) begin
                m_ghr = (m_ghr * 2 + int'(ftk)) % (1 << GHR_W);
            end else if (fty == T_CALL) begin
                m_ras[m_sp] = bpif.pc_i + 4;
                m_sp = (m_sp + 1) % RAS_DEPTH;
                m_sc = (m_sc < RAS_DEPTH) ? m_sc + 1 : RAS_DEPTH;
            end else if (fty == T_RET && m_sc > 0) begin
                m_sp = (m_sp + RAS_DEPTH - 1) % RAS_DEPTH;
                m_sc = m_sc - 1;
            end
        end
    endtask

    task automatic step(string tag);
        bit hit, tk;
        int fty;
        logic [31:0] npc;
        #1;
        m_lookup(bpif.pc_i, hit, fty, npc, tk);
        chk({tag, ".npc"}, bpif.next_pc_o, npc);
        chk({tag, ".tk"},  bpif.next_taken_o, tk);
        chk({tag, ".ghr"}, bpif.pred_ghr_o, m_ghr);
        chk({tag, ".cnt"}, bpif.ras_count_o, m_sc);
        m_update(hit, fty, tk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_fetch(logic [31:0] pc, bit fire);
        bpif.pc_i = pc;
        bpif.fetch_fire_i = fire;
    endtask

    task automatic set_br(bit req, logic [31:0] pc, logic [31:0] tgt,
                          bit tk, int ty, bit mp, logic [7:0] g);
        bpif.br_req_i        = req;
        bpif.br_pc_i         = pc;
        bpif.br_target_i     = tgt;
        bpif.br_taken_i      = tk;
        bpif.br_is_call_i    = (ty == T_CALL);
        bpif.br_is_ret_i     = (ty == T_RET);
        bpif.br_is_jmp_i     = (ty == T_JMP);
        bpif.br_mispredict_i = mp;
        bpif.br_ghr_i        = g;
    endtask

    task automatic train(logic [31:0] pc, logic [31:0] tgt, int ty);
        set_fetch(32'h0, 0);
        set_br(1, pc, tgt, 1, ty, 0, 8'h00);
        step("train");
        set_br(0, 0, 0, 0, T_COND, 0, 8'h00);
    endtask

    task automatic fetch(string tag, logic [31:0] pc, bit fire);
        set_fetch(pc, fire);
        set_br(0, 0, 0, 0, T_COND, 0, 8'h00);
        step(tag);
    endtask

    initial begin
        logic [31:0] ra_pc;
        logic [31:0] exp_pc;
        int ty;
        bit tk;

        set_fetch(32'h100, 0);
        set_br(0, 0, 0, 0, T_COND, 0, 8'h00);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        #1;
        chk("rst.npc", bpif.next_pc_o, 32'h104);
        chk("rst.tk",  bpif.next_taken_o, 1'b0);
        chk("rst.ghr", bpif.pred_ghr_o, 8'h00);
        chk("rst.cnt", bpif.ras_count_o, 4'd0);
        fetch("rst", 32'h100, 0);

        // conditional trained twice, then predicted taken
        train(32'h200, 32'h80, T_COND);
        train(32'h200, 32'h80, T_COND);
        set_fetch(32'h200, 0);
        #1;
        chk("cond.npc", bpif.next_pc_o, 32'h80);
        chk("cond.tk",  bpif.next_taken_o, 1'b1);
        fetch("cond", 32'h200, 0);

        // call then return
        train(32'h300, 32'h1000, T_CALL);
        train(32'h1010, 32'h5555_0000, T_RET);
        fetch("call", 32'h300, 1);
        chk("call.cnt", bpif.ras_count_o, 4'd1);
        set_fetch(32'h1010, 1);
        #1;
        chk("ret.npc", bpif.next_pc_o, 32'h304);
        step("ret");
        chk("ret.cnt", bpif.ras_count_o, 4'd0);

        // nine nested calls overflow an 8-deep stack
        for (int k = 0; k < 9; k++)
            train(32'h2040 + 32'(4 * k), 32'h6000, T_CALL);
        for (int k = 0; k < 9; k++)
            fetch("ncall", 32'h2040 + 32'(4 * k), 1);
        chk("ovf.cnt", bpif.ras_count_o, 4'd8);
        for (int j = 1; j <= 9; j++) begin
            exp_pc = (j == 9) ? 32'h5555_0000
                              : 32'h2040 + 32'(4 * (9 - j)) + 32'h4;
            set_fetch(32'h1010, 1);
            #1;
            chk("ovf.pop", bpif.next_pc_o, exp_pc);
            step("pop");
        end

        // same-cycle mispredict beats fetch GHR shift
        train(32'h604, 32'h40, T_COND);
        set_fetch(32'h604, 1);
        #1;
        chk("mp.hit", bpif.next_taken_o, 1'b1);
        set_br(1, 32'h604, 32'h40, 1, T_COND, 1, 8'h5A);
        step("mp");
        set_br(0, 0, 0, 0, T_COND, 0, 8'h00);
        #1;
        chk("mp.ghr", bpif.pred_ghr_o, 8'hB5);
        fetch("mp2", 32'h0, 0);

        // BTB aliasing
        train(32'h800, 32'h3000, T_JMP);
        set_fetch(32'h800, 0);
        #1;
        chk("alias.a", bpif.next_pc_o, 32'h3000);
        train(32'h900, 32'h4000, T_JMP);
        set_fetch(32'h800, 0);
        #1;
        chk("alias.npc", bpif.next_pc_o, 32'h804);
        chk("alias.tk",  bpif.next_taken_o, 1'b0);
        fetch("alias", 32'h800, 0);

        // randomized traffic with a mid-run reset
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                set_fetch(32'h0, 1);
                set_br(1, 32'h0, 32'h0, 1, T_CALL, 1, 8'hFF);
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                chk("mrst.ghr", bpif.pred_ghr_o, 8'h00);
                chk("mrst.cnt", bpif.ras_count_o, 4'd0);
                chk("mrst.tk",  bpif.next_taken_o, 1'b0);
                @(negedge clk);
                rst = 1'b0;
            end
            set_fetch({22'h0, 2'($urandom_range(0, 3)),
                       3'($urandom_range(0, 7)), 5'h0} >> 3,
                      bit'($urandom_range(0, 1)));
            ty = int'($urandom_range(0, 3));
            tk = (ty == T_COND) ? bit'($urandom_range(0, 1)) : 1'b1;
            ra_pc = {22'h0, 2'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), 5'h0} >> 3;
            set_br(bit'($urandom_range(0, 1)), ra_pc,
                   {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                   tk, ty, ($urandom_range(0, 3) == 0),
                   8'($urandom_range(0, 255)));
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
